// File: rtl/ccc_lock_sequencer.sv
// CCC PLL lock sequencer: synchronizes LOCK, waits for a stable lock, releases the
// GL0/GL1 system reset, then enables the gated GL1 clock. Tracks and counts lock losses.
module ccc_lock_sequencer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned GL1_EN_DELAY  = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       LOCK,
  input  logic       ENABLE_REQ,
  input  logic       CLR_FAULT,
  output logic       GL1_EN,
  output logic       SYS_RESET_N,
  output logic       READY,
  output logic       LOCK_LOST,
  output logic [7:0] LOSS_COUNT
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned LC_W  = 8;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(GL1_EN_DELAY - 1);
  localparam logic [LC_W-1:0]  LC_MAX       = {LC_W{1'b1}};

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_sync;
  logic                   fault_entry;
  logic                   gl1_en_d, sys_reset_n_d, ready_d, lock_lost_d;
  logic [LC_W-1:0]        loss_count_d;

  // Only sync_q[0] ever samples the raw, asynchronous LOCK.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], LOCK};
    end
  end

  assign lock_sync = sync_q[SYNC_STAGES-1];

  // State, shared counter and all outputs are registered together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      GL1_EN      <= 1'b0;
      SYS_RESET_N <= 1'b0;
      READY       <= 1'b0;
      LOCK_LOST   <= 1'b0;
      LOSS_COUNT  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      GL1_EN      <= gl1_en_d;
      SYS_RESET_N <= sys_reset_n_d;
      READY       <= ready_d;
      LOCK_LOST   <= lock_lost_d;
      LOSS_COUNT  <= loss_count_d;
    end
  end

  // Next state / counter; lock loss is only a fault once the settle phase is over.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      RELEASE: begin
        if (!lock_sync) begin
          state_d = FAULT;
          cnt_d   = '0;
        end else if (cnt_q == RELEASE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      RUN: begin
        if (!lock_sync) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values derive from the state being entered so they land on the entry edge.
  always_comb begin
    fault_entry   = (state_d == FAULT) && (state_q != FAULT);
    ready_d       = (state_d == RUN);
    gl1_en_d      = (state_d == RUN) && ENABLE_REQ;
    sys_reset_n_d = (state_d == RELEASE) || (state_d == RUN);
    lock_lost_d   = LOCK_LOST;
    loss_count_d  = LOSS_COUNT;
    if (fault_entry) begin
      lock_lost_d = 1'b1;
      if (LOSS_COUNT != LC_MAX) begin
        loss_count_d = LC_W'(LOSS_COUNT + LC_W'(1));
      end
    end else if (CLR_FAULT) begin
      lock_lost_d = 1'b0;
    end
  end

endmodule
